video_tgen: RTL and testbench
=============================

VIDEO_TGEN -- requirements
Module: video_tgen

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, sets the width of do_o.
REQ-002 Parameter CNT_WIDTH, default 16, sets the width of the line and frame counters and their configuration inputs.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run request; sampled only at frame start.
REQ-006 pix_period  input  8  clocks per pixel slot; 0 is treated as 1.
REQ-007 line_size  input  CNT_WIDTH  pixels per line; 0 is treated as 1.
REQ-008 frame_lines  input  CNT_WIDTH  lines per frame; 0 is treated as 1.
REQ-009 pattern  input  2  pattern select: 0 x-gradient, 1 y-gradient, 2 (x+y), 3 frame index.
REQ-010 do_o  output  PIXEL_WIDTH  pixel data; valid while de_o is high, held otherwise.
REQ-011 de_o  output  1  single-cycle pixel strobe.
REQ-012 hs_o  output  1  single-cycle pulse coincident with de_o of the last pixel of each line.
REQ-013 vs_o  output  1  single-cycle pulse coincident with hs_o of the last line of each frame.
REQ-014 busy_o  output  1  high while a frame is in progress.

Function
REQ-015 The block shall implement the states IDLE and RUN.
- IDLE->RUN when en=1 at a frame start.
- RUN->IDLE at frame end when en=0.
- RUN->RUN at frame end when en=1.
REQ-016 On every IDLE->RUN transition and at every frame end, the block shall latch pix_period, line_size, frame_lines and pattern into shadow registers; mid-frame input changes shall have no effect.
REQ-017 In RUN, the slot counter shall count 0..P-1, and de_o shall assert for one clock when it equals P-1, so the first de_o of a frame appears on the P-th rising edge after the IDLE->RUN edge.
REQ-018 The x counter shall increment per de_o and wrap from L-1 to 0, asserting hs_o on the wrapping pixel.
REQ-019 The y counter shall increment per hs_o and wrap from N-1 to 0, asserting vs_o on the wrapping line.
REQ-020 The frame index shall increment modulo 2^PIXEL_WIDTH on each vs_o.
REQ-021 The data source for do_o shall be selected by pattern:
- 0: x[PIXEL_WIDTH-1:0]
- 1: y[PIXEL_WIDTH-1:0]
- 2: (x+y)[PIXEL_WIDTH-1:0], wrapping
- 3: frame index
REQ-022 do_o, de_o, hs_o and vs_o shall be registered with zero skew between them.
REQ-023 With P=1, de_o shall be high every clock of a frame with no gaps.
REQ-024 With L=1, hs_o shall accompany every de_o.
- With L=1 and N=1, vs_o shall also accompany every de_o.
REQ-025 Deasserting en mid-frame shall not truncate the frame; the frame completes, then the block returns to IDLE.
REQ-026 busy_o shall be high from the IDLE->RUN edge through the clock carrying the final vs_o of the last frame.
REQ-027 Back-to-back frames shall have no extra gap: the slot counter runs continuously across frame ends.

Reset
REQ-028 While rst_n=0, the block shall hold the following values, overriding any in-flight frame immediately:
- de_o, hs_o, vs_o, busy_o = 0
- do_o = 0
- all counters and the frame index = 0
- state = IDLE
REQ-029 After rst_n rises, the first frame shall start on the first rising edge at which en=1.

Configuration
REQ-030 The macro VIDEO_TGEN_BORDER_EN shall control border forcing.
- Defined: do_o shall be forced to all ones when x==0, x==L-1, y==0 or y==N-1, overriding pattern.
- Undefined: no border logic shall be present and do_o follows REQ-021 only.

Verification
REQ-031 Reset with en=1, P=6, L=756, N=288, pattern=0 -> the first de_o at edge 6, do_o=0,1,2... spaced 6 clocks, hs_o on pixel 755 (do_o=0xF3), vs_o after 288 lines.
REQ-032 P=1, L=4, N=3, pattern=2 -> 12 consecutive de_o, do_o=0,1,2,3,1,2,3,4,2,3,4,5, hs_o on pixels 3/7/11, vs_o on pixel 11, and the next frame starts on the next clock.
REQ-033 P=0, L=0, N=0 -> de_o, hs_o and vs_o all high every clock.
REQ-034 Change line_size from 8 to 4 at mid-frame, then drop en -> the current frame keeps 8 pixels per line, busy_o falls after its vs_o, and no further de_o appears.
REQ-035 Assert rst_n=0 mid-line during RUN -> all outputs read 0 in the same cycle, and after release with en=1 a frame restarts from x=0, y=0.
REQ-036 With VIDEO_TGEN_BORDER_EN, L=4, N=4, pattern=3 -> 0xFF at all 12 edge pixels and the frame index at the 4 interior pixels.

Source files
------------

// File: rtl/video_tgen.sv
// Video timing/test-pattern generator.
// Emits a registered pixel strobe (de_o) every pix_period clocks, with line (hs_o) and
// frame (vs_o) pulses on the last pixel of each line/frame and a selectable test pattern
// on do_o. Configuration is captured at frame boundaries only.
// Optional feature: define VIDEO_TGEN_BORDER_EN to force do_o to all ones on the frame border.
module video_tgen #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [7:0]             pix_period,
  input  logic [CNT_WIDTH-1:0]   line_size,
  input  logic [CNT_WIDTH-1:0]   frame_lines,
  input  logic [1:0]             pattern,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             per_q;
  logic [CNT_WIDTH-1:0]   len_q, lines_q;
  logic [1:0]             pat_q;
  logic [7:0]             slot_q;
  logic [CNT_WIDTH-1:0]   x_q, y_q;
  logic [PIXEL_WIDTH-1:0] frame_q;
  logic [PIXEL_WIDTH-1:0] do_q;
  logic                   de_q, hs_q, vs_q, busy_q;

  logic                   slot_end, line_end, frame_end, load_cfg, busy_d;
  logic [7:0]             per_in;
  logic [CNT_WIDTH-1:0]   len_in, lines_in;
  logic [PIXEL_WIDTH-1:0] pix_d;

  // Zero-valued configuration inputs are treated as 1.
  always_comb begin
    per_in   = (pix_period == 8'd0) ? 8'd1 : pix_period;
    len_in   = (line_size == '0) ? CNT_WIDTH'(1) : line_size;
    lines_in = (frame_lines == '0) ? CNT_WIDTH'(1) : frame_lines;
  end

  // Slot/line/frame end decode from the current counters and shadow configuration.
  always_comb begin
    slot_end  = (state_q == StRun) && (slot_q == per_q - 8'd1);
    line_end  = slot_end && (x_q == len_q - CNT_WIDTH'(1));
    frame_end = line_end && (y_q == lines_q - CNT_WIDTH'(1));
  end

  // Next state, config capture and busy extension through the final vs_o cycle.
  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d  = StRun;
          load_cfg = 1'b1;
        end
      end
      StRun: begin
        if (frame_end) begin
          load_cfg = 1'b1;
          if (!en) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun) || frame_end;
  end

  // Pattern source, with optional border override.
  always_comb begin
    pix_d = '0;
    unique case (pat_q)
      2'd0: pix_d = PIXEL_WIDTH'(x_q);
      2'd1: pix_d = PIXEL_WIDTH'(y_q);
      2'd2: pix_d = PIXEL_WIDTH'(x_q + y_q);
      2'd3: pix_d = frame_q;
      default: pix_d = '0;
    endcase
`ifdef VIDEO_TGEN_BORDER_EN
    if ((x_q == '0) || (x_q == len_q - CNT_WIDTH'(1)) ||
        (y_q == '0) || (y_q == lines_q - CNT_WIDTH'(1))) begin
      pix_d = '1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Counters, shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q   <= 8'd1;
      len_q   <= CNT_WIDTH'(1);
      lines_q <= CNT_WIDTH'(1);
      pat_q   <= 2'd0;
      slot_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      do_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      de_q   <= slot_end;
      hs_q   <= line_end;
      vs_q   <= frame_end;
      busy_q <= busy_d;
      if (slot_end) do_q <= pix_d;
      if (load_cfg) begin
        per_q   <= per_in;
        len_q   <= len_in;
        lines_q <= lines_in;
        pat_q   <= pattern;
      end
      // Slot counter free-runs across frame ends so back-to-back frames have no gap.
      if (state_q == StRun) slot_q <= slot_end ? 8'd0 : slot_q + 8'd1;
      else                  slot_q <= 8'd0;
      if (slot_end) x_q <= line_end ? '0 : x_q + CNT_WIDTH'(1);
      if (line_end) y_q <= frame_end ? '0 : y_q + CNT_WIDTH'(1);
      if (frame_end) frame_q <= frame_q + PIXEL_WIDTH'(1);
    end
  end

  assign do_o   = do_q;
  assign de_o   = de_q;
  assign hs_o   = hs_q;
  assign vs_o   = vs_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_video_tgen.sv
// Scoreboard bench for video_tgen: each run pushes expected pixels (data, hs, vs, edge
// number) and a negedge monitor pops and compares them as de_o appears.
`timescale 1ns/1ps
module tb_video_tgen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  pix_period = 8'd1;
  logic [15:0] line_size = 16'd1;
  logic [15:0] frame_lines = 16'd1;
  logic [1:0]  pattern = 2'd0;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o, busy_o;

  typedef struct {
    logic [7:0] d;
    logic       hs;
    logic       vs;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   tb_fidx = 0;

  video_tgen #(.PIXEL_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pix_period  (pix_period),
    .line_size   (line_size),
    .frame_lines (frame_lines),
    .pattern     (pattern),
    .do_o        (do_o),
    .de_o        (de_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp expected pixels.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input int x, input int y, input logic [1:0] pat,
                                           input int le, input int ne, input int fidx);
    logic [7:0] r;
    case (pat)
      2'd0:    r = 8'(x);
      2'd1:    r = 8'(y);
      2'd2:    r = 8'(x + y);
      default: r = 8'(fidx);
    endcase
`ifdef VIDEO_TGEN_BORDER_EN
    if (x == 0 || x == le - 1 || y == 0 || y == ne - 1) r = 8'hFF;
`endif
    return r;
  endfunction

  // Drive a configuration with en=1 and push the expected pixel stream from x=0, y=0.
  // Must be called just after a falling edge; the next rising edge is the start edge.
  task automatic push_run(input int p, input int l, input int n, input logic [1:0] pat,
                          input int count);
    int   pe, le, ne, x, y, s;
    exp_t e;
    pe = (p == 0) ? 1 : p;
    le = (l == 0) ? 1 : l;
    ne = (n == 0) ? 1 : n;
    x = 0;
    y = 0;
    pix_period  = 8'(p);
    line_size   = 16'(l);
    frame_lines = 16'(n);
    pattern     = pat;
    en          = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < count; k++) begin
      e.d  = model_pix(x, y, pat, le, ne, tb_fidx);
      e.hs = (x == le - 1);
      e.vs = e.hs && (y == ne - 1);
      e.at = s + pe * (k + 1);
      q.push_back(e);
      if (e.hs) begin
        x = 0;
        if (e.vs) begin
          y = 0;
          tb_fidx = (tb_fidx + 1) % 256;
        end else begin
          y++;
        end
      end else begin
        x++;
      end
    end
  endtask

  task automatic wait_q(input int lim, input int budget);
    int n = 0;
    while (q.size() > lim && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > lim) begin
      check_eq("timeout", q.size(), lim);
      q.delete();
    end
  endtask

  // Drain the scoreboard, then busy_o must drop on the clock after the final vs_o.
  task automatic finish_run(input int budget);
    wait_q(0, budget);
    @(negedge clk);
    #1;
    check_eq("busy_idle", {31'b0, busy_o}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Output monitor: compare each strobe against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (de_o) begin
      if (q.size() == 0) begin
        check_eq("spurious_de", {31'b0, de_o}, 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("do", {24'b0, do_o}, {24'b0, e.d});
        check_eq("hs", {31'b0, hs_o}, {31'b0, e.hs});
        check_eq("vs", {31'b0, vs_o}, {31'b0, e.vs});
        check_eq("edge", cyc, e.at);
        check_eq("busy_run", {31'b0, busy_o}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_do", {24'b0, do_o}, 32'd0);
    check_eq("rst_de", {31'b0, de_o}, 32'd0);
    check_eq("rst_hs", {31'b0, hs_o}, 32'd0);
    check_eq("rst_vs", {31'b0, vs_o}, 32'd0);
    check_eq("rst_busy", {31'b0, busy_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // P=1, L=4, N=3, x+y pattern: two back-to-back frames, en dropped in the second.
    push_run(1, 4, 3, 2'd2, 24);
    wait_q(6, 200);
    en = 1'b0;
    finish_run(200);

    // Zero config treated as 1: every clock is a pixel, line end and frame end.
    push_run(0, 0, 0, 2'd3, 4);
    wait_q(1, 100);
    en = 1'b0;
    finish_run(100);

    // Mid-frame line_size change and en drop must not affect the running frame.
    push_run(2, 8, 3, 2'd0, 24);
    wait_q(20, 100);
    line_size = 16'd4;
    en = 1'b0;
    finish_run(200);

    // Long line with P=6: full first line (hs on x=755) plus a few pixels of the next.
    push_run(6, 756, 288, 2'd0, 759);
    wait_q(0, 6000);
    repeat (2) @(negedge clk);
    #1;
    // Asynchronous reset mid-line clears outputs immediately.
    rst_n = 1'b0;
    #1;
    check_eq("arst_do", {24'b0, do_o}, 32'd0);
    check_eq("arst_de", {31'b0, de_o}, 32'd0);
    check_eq("arst_hs", {31'b0, hs_o}, 32'd0);
    check_eq("arst_vs", {31'b0, vs_o}, 32'd0);
    check_eq("arst_busy", {31'b0, busy_o}, 32'd0);
    tb_fidx = 0;
    q.delete();
    @(negedge clk);
    #1;
    // Release with en=1: frame restarts from x=0, y=0 on the first edge.
    rst_n = 1'b1;
    push_run(1, 3, 2, 2'd2, 6);
    wait_q(3, 100);
    en = 1'b0;
    finish_run(100);

    // Frame-index pattern on a 4x4 frame (border forced when the option is built in).
    push_run(3, 4, 4, 2'd3, 16);
    wait_q(8, 200);
    en = 1'b0;
    finish_run(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
